// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP-chain constants, upsampler state encoding and the signed saturation helper.
package dsp_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int ZERO_STUFF  = 0;
    localparam int SAMPLE_HOLD = 1;

    typedef enum logic {IDLE, EMIT} up_state_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/sat_shift.sv
// sat_shift: combinational signed left shift by S bits, saturated back to N bits.
module sat_shift
    import dsp_pkg::*;
#(
    parameter int N = SAMPLE_W,
    parameter int S = 2
)(
    input  logic signed [N-1:0] i_x,
    output logic signed [N-1:0] o_y
);

    logic signed [63:0] w_wide;

    assign w_wide = 64'(i_x) <<< S;
    assign o_y    = N'(sat(w_wide, N));

endmodule

// File: rtl/upsampler.sv
// upsampler: emits L output samples per accepted input, zero-stuffed (optional gain) or held,
// with a one-deep input buffer so the source keeps flowing while the current group drains.
module upsampler
    import dsp_pkg::*;
#(
    parameter int N    = SAMPLE_W,
    parameter int L    = 4,
    parameter int logL = 2,
    parameter int HOLD = ZERO_STUFF,
    parameter int GAIN = 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] sample,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] sampleu,
    output logic                out_first,
    output logic [logL-1:0]     out_phase
);

    up_state_t          r_state, w_state_n;
    logic [logL-1:0]    r_phase, w_phase_n;
    logic signed [N-1:0] r_cur, w_cur_n;
    logic signed [N-1:0] r_nxt, w_nxt_n;
    logic               r_nxt_vld, w_nxt_vld_n;
    logic               w_acc, w_hs, w_last;
    logic signed [N-1:0] w_shift, w_scaled;

    sat_shift #(.N(N), .S(logL)) u_sat (.i_x(r_cur), .o_y(w_shift));

    assign w_acc  = in_valid && in_ready;
    assign w_hs   = out_valid && out_ready;
    assign w_last = r_phase == logL'(L - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_cur     <= '0;
            r_nxt     <= '0;
            r_nxt_vld <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_phase   <= w_phase_n;
            r_cur     <= w_cur_n;
            r_nxt     <= w_nxt_n;
            r_nxt_vld <= w_nxt_vld_n;
        end
    end

    // L is a power of two, so the phase increment wraps to 0 at the end of a group.
    always_comb begin
        w_state_n   = r_state;
        w_phase_n   = r_phase;
        w_cur_n     = r_cur;
        w_nxt_n     = r_nxt;
        w_nxt_vld_n = r_nxt_vld;
        if (r_state == IDLE) begin
            if (w_acc) begin
                w_state_n = EMIT;
                w_cur_n   = sample;
                w_phase_n = '0;
            end
        end else begin
            if (w_hs) begin
                w_phase_n = r_phase + 1'b1;
                if (w_last) begin
                    if (r_nxt_vld) begin
                        w_cur_n     = r_nxt;
                        w_nxt_vld_n = 1'b0;
                    end else if (w_acc) begin
                        w_cur_n = sample;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            if (w_acc && !(w_hs && w_last)) begin
                w_nxt_n     = sample;
                w_nxt_vld_n = 1'b1;
            end
        end
    end

    assign w_scaled  = (HOLD == SAMPLE_HOLD || GAIN == 0) ? r_cur : w_shift;
    assign in_ready  = !r_nxt_vld;
    assign out_valid = r_state == EMIT;
    assign out_phase = r_phase;
    assign out_first = out_valid && r_phase == '0;
    assign sampleu   = !out_valid ? '0 : (r_phase == '0) ? w_scaled : (HOLD == SAMPLE_HOLD) ? r_cur : '0;

endmodule

// File: tb/tb_upsampler.sv
// tb_upsampler: directed checks of zero-stuff (with and without gain), saturation, hold,
// backpressure, bypass and asynchronous reset, on three parameterisations sharing one stimulus.
module tb_upsampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] sample = '0;
    int          total = 0;
    int          bad = 0;

    logic        a_in_ready, a_out_valid, a_out_first;
    logic [15:0] a_sampleu;
    logic [1:0]  a_out_phase;
    logic        z_in_ready, z_out_valid, z_out_first;
    logic [15:0] z_sampleu;
    logic [1:0]  z_out_phase;
    logic        h_in_ready, h_out_valid, h_out_first;
    logic [15:0] h_sampleu;
    logic [1:0]  h_out_phase;

    always #5 clk = ~clk;

    upsampler #(.N(16), .L(4), .logL(2), .HOLD(0), .GAIN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .sample(sample),
        .out_valid(a_out_valid), .out_ready(out_ready), .sampleu(a_sampleu),
        .out_first(a_out_first), .out_phase(a_out_phase));

    upsampler #(.N(16), .L(4), .logL(2), .HOLD(0), .GAIN(0)) u_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready), .sample(sample),
        .out_valid(z_out_valid), .out_ready(out_ready), .sampleu(z_sampleu),
        .out_first(z_out_first), .out_phase(z_out_phase));

    upsampler #(.N(16), .L(4), .logL(2), .HOLD(1), .GAIN(1)) u_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready), .sample(sample),
        .out_valid(h_out_valid), .out_ready(out_ready), .sampleu(h_sampleu),
        .out_first(h_out_first), .out_phase(h_out_phase));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two back-to-back inputs on the gain instance; the second waits in the buffer.
    task automatic run_pair(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] e0, input logic [15:0] e4);
        logic [15:0] exp_v [8];
        exp_v = '{e0, 16'h0, 16'h0, 16'h0, e4, 16'h0, 16'h0, 16'h0};
        in_valid = 1'b1;
        sample   = s0;
        step();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pair_valid%0d", i), a_out_valid, 1);
            check($sformatf("pair_data%0d", i), a_sampleu, exp_v[i]);
            check($sformatf("pair_first%0d", i), a_out_first, (i % 4) == 0);
            check($sformatf("pair_phase%0d", i), a_out_phase, i % 4);
            if (i == 0) sample = s1;
            else in_valid = 1'b0;
            step();
        end
        check("pair_idle", a_out_valid, 0);
    endtask

    initial begin
        logic [15:0] q [3];
        logic [15:0] bp_exp [12];
        logic [15:0] held_d;
        logic [1:0]  held_p;
        int          qi, idx, done, stalls, cyc;
        logic        saw_block, acc, hs;

        #3;
        check("rst_valid", z_out_valid, 0);
        check("rst_ready", z_in_ready, 1);
        check("rst_data", z_sampleu, 0);
        check("rst_first", z_out_first, 0);
        check("rst_phase", z_out_phase, 0);
        step();
        rst_n = 1'b1;
        step();

        // reset in the middle of a group
        in_valid = 1'b1;
        sample   = 16'h1234;
        step();
        in_valid = 1'b0;
        check("mid_b0", z_sampleu, 16'h1234);
        check("mid_f0", z_out_first, 1);
        step();
        check("mid_b1", z_sampleu, 16'h0000);
        check("mid_v1", z_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", z_out_valid, 0);
        check("mid_rst_ready", z_in_ready, 1);
        check("mid_rst_data", z_sampleu, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid_after%0d", i), z_out_valid, 0);
        end

        run_pair(16'h0100, 16'hFF00, 16'h0400, 16'hFC00);
        run_pair(16'h3000, 16'h9000, 16'h7FFF, 16'h8000);

        // sample and hold
        in_valid = 1'b1;
        sample   = 16'hABCD;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_data%0d", i), h_sampleu, 16'hABCD);
            check($sformatf("hold_phase%0d", i), h_out_phase, i);
            check($sformatf("hold_valid%0d", i), h_out_valid, 1);
            step();
        end
        check("hold_idle", h_out_valid, 0);

        // backpressure with three queued samples
        q      = '{16'h0001, 16'h0002, 16'h0003};
        bp_exp = '{16'h4, 16'h0, 16'h0, 16'h0, 16'h8, 16'h0, 16'h0, 16'h0, 16'hC, 16'h0, 16'h0, 16'h0};
        qi = 0; idx = 0; done = 0; stalls = 0; saw_block = 1'b0;
        held_d = '0; held_p = '0;
        for (cyc = 0; cyc < 40; cyc++) begin
            in_valid = qi < 3;
            sample   = (qi < 3) ? q[qi] : 16'h0;
            if (a_out_valid && a_out_phase == 2 && stalls < 5) begin
                out_ready = 1'b0;
                if (stalls == 0) begin
                    held_d = a_sampleu;
                    held_p = a_out_phase;
                end else begin
                    check($sformatf("bp_hold_d%0d", stalls), a_sampleu, held_d);
                    check($sformatf("bp_hold_p%0d", stalls), a_out_phase, held_p);
                    check($sformatf("bp_hold_v%0d", stalls), a_out_valid, 1);
                end
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            check($sformatf("bp_ready%0d", cyc), a_in_ready, (qi - done) < 2);
            if (!a_in_ready) saw_block = 1'b1;
            acc = in_valid && a_in_ready;
            hs  = a_out_valid && out_ready;
            if (hs) begin
                if (idx < 12) begin
                    check($sformatf("bp_data%0d", idx), a_sampleu, bp_exp[idx]);
                    check($sformatf("bp_phase%0d", idx), a_out_phase, idx % 4);
                end
                if (a_out_phase == 3) done++;
                idx++;
            end
            step();
            if (acc) qi++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_beats", idx, 12);
        check("bp_taken", qi, 3);
        check("bp_blocked", saw_block, 1);
        check("bp_idle", a_out_valid, 0);

        // new sample arrives exactly on the last beat with the buffer empty
        in_valid = 1'b1;
        sample   = 16'h0010;
        step();
        in_valid = 1'b0;
        check("byp_d0", a_sampleu, 16'h0040);
        step();
        step();
        step();
        check("byp_ph3", a_out_phase, 3);
        check("byp_rdy3", a_in_ready, 1);
        in_valid = 1'b1;
        sample   = 16'h0020;
        step();
        in_valid = 1'b0;
        check("byp_valid", a_out_valid, 1);
        check("byp_phase", a_out_phase, 0);
        check("byp_first", a_out_first, 1);
        check("byp_data", a_sampleu, 16'h0080);
        check("byp_ready", a_in_ready, 1);
        check("byp_hold", h_sampleu, 16'h0020);
        for (int i = 0; i < 4; i++) step();
        check("byp_idle", a_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
